regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Debug/readout engine that drives a read port of the 32x32 integer register file. On a start pulse it sweeps addresses 0..NUM_REGS-1 and captures each word. It streams each word out over a valid/ready interface with its address, then optionally sends a trailing XOR checksum word. It sits beside the register file, on a spare read port or a muxed rs1 port used while the core is halted, and feeds a debug/UART transmitter.

Parameters:
NUM_REGS, 32, number of registers swept, starting at address 0
ADDR_W, 5, register address width
DATA_W, 32, register data width
APPEND_CSUM, 1, 1 = send an XOR checksum word after the last register; 0 = no checksum word

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous, active-high reset
Start  input  1  begin dump; sampled only in IDLE
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse when the dump completes
RdAddr  output  ADDR_W  register file read address (async read port)
RdData  input  DATA_W  register file read data, combinational from RdAddr
OutData  output  DATA_W  stream word (register value or checksum)
OutAddr  output  ADDR_W  register index of OutData; 0 for the checksum word
OutValid  output  1  stream word valid
OutReady  input  1  downstream accepts when OutValid&&OutReady at a rising edge
OutLast  output  1  marks the final word of the dump

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE, idx=0, csum=0. RdAddr=0, OutData=0, OutAddr=0, OutValid=0, OutLast=0, Busy=0, Done=0. Reset mid-dump aborts at once; OutValid drops on the next cycle and no partial checksum is sent.
- All outputs are registered. RdAddr = idx.
- States: IDLE, FETCH, SEND, CSUM, DONE.
- IDLE: Start=1 -> idx=0, csum=0, go to FETCH. Start=0 -> stay.
- FETCH (1 cycle):
  - OutData<=RdData (addr idx), OutAddr<=idx, OutValid<=1.
  - OutLast<=1 when idx==NUM_REGS-1 and APPEND_CSUM==0.
  - Go to SEND.
- SEND:
  - Hold OutData/OutAddr/OutLast stable while OutValid&&!OutReady.
  - On handshake: csum<=csum^OutData, OutValid<=0.
    - idx==NUM_REGS-1 -> CSUM if APPEND_CSUM, else DONE.
    - Otherwise idx<=idx+1, go to FETCH.
- CSUM:
  - On entry: OutData=csum (includes all NUM_REGS words), OutAddr=0, OutLast=1, OutValid=1.
  - Hold until handshake, then OutValid<=0, OutLast<=0, go to DONE.
- DONE: Done=1 for exactly this cycle; next state IDLE.
- Timing: Start sampled at edge T -> FETCH in cycle T+1 -> OutValid first high in cycle T+2.
  - OutReady tied high: one word per 2 cycles.
  - Total: Start edge to Done pulse = 2*NUM_REGS + 2*APPEND_CSUM + 1 cycles (65 or 67 with defaults).
- Start while Busy (including DONE) is ignored; there is no queued restart.
- Consistency: each word is captured in its FETCH cycle. Writes to the register file during a dump show up in any word not yet fetched. Callers halt the core for an atomic snapshot.
- Address 0 is read like any other address; the register file guarantees 0 there.
- idx never wraps: the sweep terminates at NUM_REGS-1.

Decomposition:
- Shared package regfile_dbg_pkg:
  - state enum {IDLE, FETCH, SEND, CSUM, DONE}
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_INT_REGS=32
- Single module; no sub-module is warranted. Counter, FSM and XOR accumulator stay inline.

Test Plan:
- Preload x0=0, xi=0xA5A50000|i for i=1..31; OutReady=1; pulse Start. Required: 33 words, addresses 0..31 with matching data, then the checksum word 0xA5A50000 with OutLast=1. Done fires exactly 67 cycles after the Start edge.
- Same preload with OutReady driven by a random 30% duty cycle. Required: identical word sequence; OutData/OutAddr stable during every stall; no word dropped or duplicated.
- APPEND_CSUM=0, all registers 0xFFFFFFFF except x0. Required: 32 words; OutLast only on addr 31; Done 65 cycles after Start; no checksum word.
- Assert Rst during SEND of word 10. Required: next cycle OutValid=0, Busy=0, RdAddr=0. A following Start restarts from addr 0 with the checksum recomputed from scratch.
- Pulse Start again at words 5 and 20 and during DONE. Required: ignored; exactly one dump, one Done pulse.
- Write x7=0x12345678 while word 3 is in SEND (x7 not yet fetched). Required: word 7 carries 0x12345678, and the checksum reflects the new value.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and sizing for the register-file debug readout path.
package regfile_dbg_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;
  localparam int NUM_INT_REGS = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CSUM,
    DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready word stream carrying a register value (or checksum) and its index.
interface regfile_dump_reader_if
  import regfile_dbg_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, addr, valid, last, input ready);
  modport slave  (input data, addr, valid, last, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Sweeps the register file read port and streams every word, then an optional XOR checksum.
// state | meaning
// IDLE  | waiting for start_i
// FETCH | capture rd_data_i at idx into the output word
// SEND  | word offered downstream, held until accepted
// CSUM  | load then offer the checksum word (addr 0, last)
// DONE  | one-cycle completion pulse
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int NUM_REGS    = NUM_INT_REGS,
  parameter int ADDR_W      = REG_ADDR_W,
  parameter int DATA_W      = REG_DATA_W,
  parameter bit APPEND_CSUM = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic [DATA_W-1:0]     rd_data_i,
  regfile_dump_reader_if.master out_if
);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              is_last;

  assign is_last = (idx_q == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          data_q  <= rd_data_i;
          addr_q  <= idx_q;
          valid_q <= 1'b1;
          last_q  <= is_last && !APPEND_CSUM;
          state_q <= SEND;
        end
        SEND: begin
          if (out_if.ready) begin
            csum_q  <= csum_q ^ data_q;
            valid_q <= 1'b0;
            if (is_last) begin
              if (APPEND_CSUM) begin
                state_q <= CSUM;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        CSUM: begin
          // First cycle loads the accumulated checksum, then it is offered like any word.
          if (!valid_q) begin
            data_q  <= csum_q;
            addr_q  <= '0;
            last_q  <= 1'b1;
            valid_q <= 1'b1;
          end else if (out_if.ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign rd_addr_o    = idx_q;
  assign out_if.data  = data_q;
  assign out_if.addr  = addr_q;
  assign out_if.valid = valid_q;
  assign out_if.last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a queue-based model of the expected dump.
module tb_regfile_dump_reader;
  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_c, start_n, ready;
  logic        busy_c, done_c, busy_n, done_n;
  logic [4:0]  rd_addr_c, rd_addr_n;
  logic [31:0] rd_data_c, rd_data_n;
  logic [31:0] regs  [N];
  logic [31:0] mregs [N];

  regfile_dump_reader_if if_c ();
  regfile_dump_reader_if if_n ();

  assign if_c.ready = ready;
  assign if_n.ready = ready;
  assign rd_data_c  = regs[rd_addr_c];
  assign rd_data_n  = regs[rd_addr_n];

  regfile_dump_reader #(.APPEND_CSUM(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .busy_o(busy_c), .done_o(done_c),
    .rd_addr_o(rd_addr_c), .rd_data_i(rd_data_c), .out_if(if_c)
  );

  regfile_dump_reader #(.APPEND_CSUM(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .start_i(start_n), .busy_o(busy_n), .done_o(done_n),
    .rd_addr_o(rd_addr_n), .rd_data_i(rd_data_n), .out_if(if_n)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [37:0] got [$];
  logic [37:0] exp [$];
  int          lat, stall_errs, done_cnt;
  bit          timeout;

  // Expected stream: {last, addr, data} per register, then the XOR of all of them.
  function automatic void build_exp(input bit csum);
    logic [31:0] x;
    x = '0;
    exp.delete();
    for (int i = 0; i < N; i++) begin
      exp.push_back({((i == N - 1) && !csum), 5'(i), mregs[i]});
      x = x ^ mregs[i];
    end
    if (csum) exp.push_back({1'b1, 5'd0, x});
  endfunction

  task automatic load_pattern_a();
    regs[0] = '0;
    for (int i = 1; i < N; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
    for (int i = 0; i < N; i++) mregs[i] = regs[i];
  endtask

  task automatic load_random();
    regs[0] = '0;
    for (int i = 1; i < N; i++) regs[i] = $urandom;
    for (int i = 0; i < N; i++) mregs[i] = regs[i];
  endtask

  // Starts one dump and records accepted words, stall stability, Done pulses and latency.
  task automatic collect(input bit sel, input int pct, input bit poke, input bit wr);
    int cyc, first_done;
    bit pend, p5, p20, pdn, wdone;
    logic [37:0] sv, w;
    logic v, l, dn;
    logic [4:0] a;
    logic [31:0] d;
    got.delete();
    lat = -1; stall_errs = 0; done_cnt = 0; timeout = 0;
    pend = 0; p5 = 0; p20 = 0; pdn = 0; wdone = 0; first_done = -1; cyc = 0; sv = '0;
    ready = ($urandom_range(0, 99) < pct);
    if (sel) start_n = 1'b1; else start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0; start_n = 1'b0;
    while (cyc < 3000 && (first_done < 0 || cyc < first_done + 80)) begin
      @(posedge clk); #1;
      cyc++;
      start_c = 1'b0;
      v  = sel ? if_n.valid : if_c.valid;
      l  = sel ? if_n.last  : if_c.last;
      a  = sel ? if_n.addr  : if_c.addr;
      d  = sel ? if_n.data  : if_c.data;
      dn = sel ? done_n     : done_c;
      w  = {l, a, d};
      if (pend && (!v || w !== sv)) stall_errs++;
      if (dn) begin
        done_cnt++;
        if (first_done < 0) begin first_done = cyc; lat = cyc + 1; end
        if (poke && !pdn) begin start_c = 1'b1; pdn = 1; end
      end
      if (poke && v && a == 5'd5  && !p5)  begin start_c = 1'b1; p5 = 1; end
      if (poke && v && a == 5'd20 && !p20) begin start_c = 1'b1; p20 = 1; end
      if (wr && v && a == 5'd3 && !wdone) begin regs[7] = 32'h1234_5678; wdone = 1; end
      ready = ($urandom_range(0, 99) < pct);
      if (v && ready) got.push_back(w);
      pend = v && !ready;
      sv = w;
    end
    if (first_done < 0) timeout = 1;
    start_c = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_c = 1'b0; start_n = 1'b0; ready = 1'b0;
    load_pattern_a();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_c.valid, if_c.last, busy_c, done_c} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {if_c.valid, if_c.last, busy_c, done_c});
    end
    n_checks++;
    if ({rd_addr_c, if_c.addr, if_c.data} !== 42'd0) begin
      n_fail++; $display("FAIL reset_bus: rd_addr %0d addr %0d data %h, expected all 0", rd_addr_c, if_c.addr, if_c.data);
    end
    n_checks++;
    if ({if_n.valid, busy_n, done_n, rd_addr_n} !== 8'd0) begin
      n_fail++; $display("FAIL reset_nocsum: got %b, expected 0", {if_n.valid, busy_n, done_n, rd_addr_n});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_ready();
    load_pattern_a();
    build_exp(1'b1);
    collect(1'b0, 100, 1'b0, 1'b0);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL full_timeout: no Done seen, expected one"); end
    n_checks++;
    if (got.size() != exp.size()) begin n_fail++; $display("FAIL full_count: got %0d words, expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL full_word[%0d]: got %h, expected %h", i, got[i], exp[i]); end
    end
    n_checks++;
    if (got.size() == 33 && got[32] !== {1'b1, 5'd0, 32'hA5A5_0000}) begin
      n_fail++; $display("FAIL full_csum: got %h, expected 1_00_a5a50000", got[32]);
    end else if (got.size() != 33) n_fail++;
    n_checks++;
    if (lat != 67) begin n_fail++; $display("FAIL full_latency: got %0d cycles, expected 67", lat); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    load_pattern_a();
    build_exp(1'b1);
    collect(1'b0, 30, 1'b0, 1'b0);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL bp_timeout: no Done seen, expected one"); end
    n_checks++;
    if (got.size() != exp.size()) begin n_fail++; $display("FAIL bp_count: got %0d words, expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h, expected %h", i, got[i], exp[i]); end
    end
    n_checks++;
    if (stall_errs != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d unstable stalls, expected 0", stall_errs); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_no_csum();
    regs[0] = '0;
    for (int i = 1; i < N; i++) regs[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) mregs[i] = regs[i];
    build_exp(1'b0);
    collect(1'b1, 100, 1'b0, 1'b0);
    n_checks++;
    if (got.size() != 32) begin n_fail++; $display("FAIL nocsum_count: got %0d words, expected 32", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL nocsum_word[%0d]: got %h, expected %h", i, got[i], exp[i]); end
    end
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL nocsum_latency: got %0d cycles, expected 65", lat); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL nocsum_done_count: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_abort_restart();
    int cyc;
    load_random();
    build_exp(1'b1);
    ready = 1'b1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    cyc = 0;
    while (!(if_c.valid && if_c.addr == 5'd10) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin n_fail++; $display("FAIL abort_reach_word10: timed out after %0d cycles, expected word 10", cyc); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({if_c.valid, busy_c, done_c, rd_addr_c} !== 8'd0) begin
      n_fail++; $display("FAIL abort_state: valid %b busy %b done %b rd_addr %0d, expected all 0", if_c.valid, busy_c, done_c, rd_addr_c);
    end
    repeat (2) @(posedge clk);
    #1;
    collect(1'b0, 100, 1'b0, 1'b0);
    n_checks++;
    if (got.size() != exp.size()) begin n_fail++; $display("FAIL restart_count: got %0d words, expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL restart_word[%0d]: got %h, expected %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_start_ignored();
    load_random();
    build_exp(1'b1);
    collect(1'b0, 60, 1'b1, 1'b0);
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d, expected 1", done_cnt); end
    n_checks++;
    if (got.size() != exp.size()) begin n_fail++; $display("FAIL ignore_count: got %0d words, expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL ignore_word[%0d]: got %h, expected %h", i, got[i], exp[i]); end
    end
    n_checks++;
    if (busy_c !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after: got %b, expected 0", busy_c); end
  endtask

  task automatic test_write_during_dump();
    load_pattern_a();
    mregs[7] = 32'h1234_5678;
    build_exp(1'b1);
    collect(1'b0, 100, 1'b0, 1'b1);
    n_checks++;
    if (got.size() != exp.size()) begin n_fail++; $display("FAIL wr_count: got %0d words, expected %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL wr_word[%0d]: got %h, expected %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_backpressure();
    test_no_csum();
    test_abort_restart();
    test_start_ignored();
    test_write_during_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
